// File: rtl/rvc_dmem_arb_pkg.sv
// Shared types and constants for the D_MEM arbiter slice.
// Arbitration FSM states, read-return owner encoding and the D_MEM address window.
package rvc_dmem_arb_pkg;

  typedef enum logic {
    CORE_PRI = 1'b0,
    EXT_PRI  = 1'b1
  } t_arb_state;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CORE = 2'd1,
    EXT  = 2'd2
  } t_dmem_owner;

  localparam logic [31:0] D_MEM_OFFSET = 32'h1000;
  localparam int          MSB_D_MEM    = 11;

  // Starvation counter width; MAX_STARVE must fit (1..15).
  localparam int STARVE_W = 4;

  // Saturating increment: the starvation counter never wraps.
  function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt,
                                                      input logic [STARVE_W-1:0] max);
    return (cnt >= max) ? max : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/rvc_dmem_arb_if.sv
// Bus bundle between the two D_MEM requesters, the arbiter and the single-port memory.
//
// Handshake semantics:
//  - CoreReq is a one-cycle request. If CoreStall=1 in the same cycle the request was
//    not taken and the core must present it again next cycle; CoreStall=0 with
//    CoreReq=1 means the access went to memory this cycle.
//  - ExtReq is held with stable Wr/Addr/WrData/ByteEn until ExtGnt=1; the access
//    goes to memory in the ExtGnt cycle.
//  - Reads return exactly one cycle after the grant on <owner>RdValid/<owner>RdData.
//    The non-owner's RdData keeps its last returned value.
//  - MemRdEn/MemWrEn strobe one access per cycle; MemRdData is valid the cycle after
//    MemRdEn.
interface rvc_dmem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // core side
  logic                CoreReq;
  logic                CoreWr;
  logic [ADDR_W-1:0]   CoreAddr;
  logic [DATA_W-1:0]   CoreWrData;
  logic [DATA_W/8-1:0] CoreByteEn;
  logic                CoreStall;
  logic [DATA_W-1:0]   CoreRdData;
  logic                CoreRdValid;
  // external debug/loader side
  logic                ExtReq;
  logic                ExtWr;
  logic [ADDR_W-1:0]   ExtAddr;
  logic [DATA_W-1:0]   ExtWrData;
  logic [DATA_W/8-1:0] ExtByteEn;
  logic                ExtGnt;
  logic [DATA_W-1:0]   ExtRdData;
  logic                ExtRdValid;
  // memory side
  logic                MemRdEn;
  logic                MemWrEn;
  logic [ADDR_W-1:0]   MemAddr;
  logic [DATA_W-1:0]   MemWrData;
  logic [DATA_W/8-1:0] MemByteEn;
  logic [DATA_W-1:0]   MemRdData;

  // Arbiter view.
  modport slave (
    input  CoreReq, CoreWr, CoreAddr, CoreWrData, CoreByteEn,
    output CoreStall, CoreRdData, CoreRdValid,
    input  ExtReq, ExtWr, ExtAddr, ExtWrData, ExtByteEn,
    output ExtGnt, ExtRdData, ExtRdValid,
    output MemRdEn, MemWrEn, MemAddr, MemWrData, MemByteEn,
    input  MemRdData
  );

  // Requesters-plus-memory view.
  modport master (
    output CoreReq, CoreWr, CoreAddr, CoreWrData, CoreByteEn,
    input  CoreStall, CoreRdData, CoreRdValid,
    output ExtReq, ExtWr, ExtAddr, ExtWrData, ExtByteEn,
    input  ExtGnt, ExtRdData, ExtRdValid,
    input  MemRdEn, MemWrEn, MemAddr, MemWrData, MemByteEn,
    output MemRdData
  );
endinterface

// File: rtl/rvc_dmem_arb_stats.sv
// Grant/conflict event counters for the D_MEM arbiter (built only with
// RVC_DMEM_ARB_STATS_EN). 32-bit, reset to 0, wrap naturally.
module rvc_dmem_arb_stats (
  input  logic        Clock,
  input  logic        Rst,
  input  logic        CoreGnt,
  input  logic        ExtGnt,
  input  logic        Conflict,
  output logic [31:0] CntCoreGnt,
  output logic [31:0] CntExtGnt,
  output logic [31:0] CntConflict
);

  // Count one event per cycle on each strobe.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      CntCoreGnt  <= '0;
      CntExtGnt   <= '0;
      CntConflict <= '0;
    end else begin
      if (CoreGnt)  CntCoreGnt  <= CntCoreGnt  + 32'd1;
      if (ExtGnt)   CntExtGnt   <= CntExtGnt   + 32'd1;
      if (Conflict) CntConflict <= CntConflict + 32'd1;
    end
  end

endmodule

// File: rtl/rvc_dmem_arb.sv
// Single-port D_MEM arbiter: core pipeline vs external debug/loader port.
// Core has priority; after MAX_STARVE consecutive lost conflicts the external port
// wins one conflict. Read data returns one cycle after grant to the owner.
// Optional build macro: RVC_DMEM_ARB_STATS_EN adds CntCoreGnt/CntExtGnt/CntConflict.
module rvc_dmem_arb
  import rvc_dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic                Clock,
  input  logic                Rst,
  rvc_dmem_arb_if.slave       bus,
  output t_arb_state          DbgState,
  output logic [STARVE_W-1:0] DbgStarveCnt
`ifdef RVC_DMEM_ARB_STATS_EN
  ,
  output logic [31:0]         CntCoreGnt,
  output logic [31:0]         CntExtGnt,
  output logic [31:0]         CntConflict
`endif
);

  localparam logic [STARVE_W-1:0] STARVE_MAX  = STARVE_W'(MAX_STARVE);
  localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(MAX_STARVE - 1);

  t_arb_state          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  t_dmem_owner         owner_q, owner_d;
  logic [DATA_W-1:0]   core_rd_q, ext_rd_q;

  logic                core_req, ext_req, conflict;
  logic                core_gnt, ext_gnt;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wr_data;
  logic [DATA_W/8-1:0] mem_byte_en;

  // Requests are ignored while reset is asserted so no strobe escapes during reset.
  assign core_req = bus.CoreReq & ~Rst;
  assign ext_req  = bus.ExtReq  & ~Rst;
  assign conflict = core_req & ext_req;

  // Same-cycle grant: core wins unless the starvation guard has flipped priority.
  always_comb begin
    core_gnt = 1'b0;
    ext_gnt  = 1'b0;
    if (conflict) begin
      core_gnt = (state_q == CORE_PRI);
      ext_gnt  = (state_q == EXT_PRI);
    end else begin
      core_gnt = core_req;
      ext_gnt  = ext_req;
    end
  end

  // Memory request mux; address/data are zero when nobody is granted.
  always_comb begin
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_byte_en = '0;
    if (core_gnt) begin
      mem_addr    = bus.CoreAddr;
      mem_wr_data = bus.CoreWrData;
      mem_byte_en = bus.CoreByteEn;
    end else if (ext_gnt) begin
      mem_addr    = bus.ExtAddr;
      mem_wr_data = bus.ExtWrData;
      mem_byte_en = bus.ExtByteEn;
    end
  end

  assign bus.MemRdEn   = (core_gnt & ~bus.CoreWr) | (ext_gnt & ~bus.ExtWr);
  assign bus.MemWrEn   = (core_gnt &  bus.CoreWr) | (ext_gnt &  bus.ExtWr);
  assign bus.MemAddr   = mem_addr;
  assign bus.MemWrData = mem_wr_data;
  assign bus.MemByteEn = mem_byte_en;
  assign bus.CoreStall = core_req & ~core_gnt;
  assign bus.ExtGnt    = ext_gnt;

  // Priority FSM and starvation counter: next-state logic.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      CORE_PRI: begin
        if (ext_gnt) begin
          starve_d = '0;
        end else if (conflict) begin
          starve_d = starve_inc(starve_q, STARVE_MAX);
          if (starve_q >= STARVE_LAST) state_d = EXT_PRI;
        end
      end
      EXT_PRI: begin
        // Leave on the forced grant, or if the external requester gave up.
        if (ext_gnt || !ext_req) begin
          state_d  = CORE_PRI;
          starve_d = '0;
        end
      end
      default: begin
        state_d  = CORE_PRI;
        starve_d = '0;
      end
    endcase
  end

  // Priority FSM and starvation counter: state register.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state_q  <= CORE_PRI;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  assign DbgState     = state_q;
  assign DbgStarveCnt = starve_q;

  // Remember who owns the read that memory will answer next cycle.
  always_comb begin
    owner_d = NONE;
    if (core_gnt && !bus.CoreWr)     owner_d = CORE;
    else if (ext_gnt && !bus.ExtWr)  owner_d = EXT;
  end

  // Read-owner register; reset drops any in-flight return.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) owner_q <= NONE;
    else     owner_q <= owner_d;
  end

  // Per-requester data hold registers capture each returned word.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      core_rd_q <= '0;
      ext_rd_q  <= '0;
    end else begin
      if (owner_q == CORE) core_rd_q <= bus.MemRdData;
      if (owner_q == EXT)  ext_rd_q  <= bus.MemRdData;
    end
  end

  assign bus.CoreRdValid = (owner_q == CORE);
  assign bus.ExtRdValid  = (owner_q == EXT);
  assign bus.CoreRdData  = (owner_q == CORE) ? bus.MemRdData : core_rd_q;
  assign bus.ExtRdData   = (owner_q == EXT)  ? bus.MemRdData : ext_rd_q;

`ifdef RVC_DMEM_ARB_STATS_EN
  rvc_dmem_arb_stats u_stats (
    .Clock       (Clock),
    .Rst         (Rst),
    .CoreGnt     (core_gnt),
    .ExtGnt      (ext_gnt),
    .Conflict    (conflict),
    .CntCoreGnt  (CntCoreGnt),
    .CntExtGnt   (CntExtGnt),
    .CntConflict (CntConflict)
  );
`endif

endmodule

// File: tb/tb_rvc_dmem_arb.sv
// Bench for rvc_dmem_arb: directed vectors, behavioural D_MEM model, and a read-return
// scoreboard monitor. Counter checks are active when RVC_DMEM_ARB_STATS_EN is defined.
module tb_rvc_dmem_arb;
  import rvc_dmem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic Clock;
  logic Rst;
  int   cyc;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  rvc_dmem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  t_arb_state  dbg_state;
  logic [3:0]  dbg_starve;
`ifdef RVC_DMEM_ARB_STATS_EN
  logic [31:0] cnt_core, cnt_ext, cnt_conf;
`endif

  rvc_dmem_arb #(.ADDR_W(32), .DATA_W(32), .MAX_STARVE(4)) dut (
    .Clock        (Clock),
    .Rst          (Rst),
    .bus          (bus),
    .DbgState     (dbg_state),
    .DbgStarveCnt (dbg_starve)
`ifdef RVC_DMEM_ARB_STATS_EN
    ,
    .CntCoreGnt   (cnt_core),
    .CntExtGnt    (cnt_ext),
    .CntConflict  (cnt_conf)
`endif
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [0:1023];

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - D_MEM_OFFSET;
    return int'(off[MSB_D_MEM:2]);
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    bus.MemRdData = '0;
  end

  always @(posedge Clock) begin
    if (bus.MemWrEn) begin
      for (int b = 0; b < 4; b++)
        if (bus.MemByteEn[b]) mem[widx(bus.MemAddr)][8*b +: 8] <= bus.MemWrData[8*b +: 8];
    end
    if (bus.MemRdEn) bus.MemRdData <= mem[widx(bus.MemAddr)];
  end

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] core_exp_q[$];
  logic [31:0] ext_exp_q[$];
  int          core_cyc_q[$];
  int          ext_cyc_q[$];
  logic [31:0] core_last = '0;
  logic [31:0] ext_last  = '0;
  logic [31:0] mon_exp;
  int          mon_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expected word per returned read and checks order, timing, hold.
  always @(negedge Clock) begin
    if (bus.CoreRdValid && bus.ExtRdValid) begin
      n_tests++;
      n_fail++;
      $display("FAIL both_valid: CoreRdValid=1 ExtRdValid=1, required at most one (cycle %0d)", cyc);
    end
    if (bus.CoreRdValid) begin
      if (core_exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL core_unexpected: CoreRdValid=1 data 0x%08h, required no return (cycle %0d)",
                 bus.CoreRdData, cyc);
      end else begin
        mon_exp = core_exp_q.pop_front();
        mon_cyc = core_cyc_q.pop_front();
        chk("core_rd_data", bus.CoreRdData, mon_exp);
        chk("core_rd_cycle", cyc, mon_cyc);
        core_last = mon_exp;
      end
      if (!bus.ExtRdValid) chk("ext_hold", bus.ExtRdData, ext_last);
    end
    if (bus.ExtRdValid) begin
      if (ext_exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL ext_unexpected: ExtRdValid=1 data 0x%08h, required no return (cycle %0d)",
                 bus.ExtRdData, cyc);
      end else begin
        mon_exp = ext_exp_q.pop_front();
        mon_cyc = ext_cyc_q.pop_front();
        chk("ext_rd_data", bus.ExtRdData, mon_exp);
        chk("ext_rd_cycle", cyc, mon_cyc);
        ext_last = mon_exp;
      end
      if (!bus.CoreRdValid) chk("core_hold", bus.CoreRdData, core_last);
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; applies one cycle of requests, checks the
  // combinational grant/strobe outputs mid-cycle, and queues expected read returns.
  task automatic drive(input logic creq, input logic cwr, input logic [31:0] caddr,
                       input logic [31:0] cdata, input logic [3:0] cbe,
                       input logic ereq, input logic ewr, input logic [31:0] eaddr,
                       input logic [31:0] edata, input logic [3:0] ebe,
                       input logic xstall, input logic xgnt,
                       input logic [31:0] xcrd, input logic [31:0] xerd, input string tag);
    logic cg, eg;
    bus.CoreReq = creq; bus.CoreWr = cwr; bus.CoreAddr = caddr;
    bus.CoreWrData = cdata; bus.CoreByteEn = cbe;
    bus.ExtReq = ereq; bus.ExtWr = ewr; bus.ExtAddr = eaddr;
    bus.ExtWrData = edata; bus.ExtByteEn = ebe;
    cg = creq & ~xstall;
    eg = xgnt;
    if (cg && !cwr) begin core_exp_q.push_back(xcrd); core_cyc_q.push_back(cyc + 1); end
    if (eg && !ewr) begin ext_exp_q.push_back(xerd);  ext_cyc_q.push_back(cyc + 1);  end
    @(negedge Clock);
    chk({tag, "_stall"}, 32'(bus.CoreStall), 32'(xstall));
    chk({tag, "_egnt"},  32'(bus.ExtGnt), 32'(xgnt));
    chk({tag, "_rden"},  32'(bus.MemRdEn), 32'((cg & ~cwr) | (eg & ~ewr)));
    chk({tag, "_wren"},  32'(bus.MemWrEn), 32'((cg & cwr) | (eg & ewr)));
    chk({tag, "_addr"},  bus.MemAddr, cg ? caddr : (eg ? eaddr : 32'h0));
    chk({tag, "_wdata"}, bus.MemWrData, cg ? cdata : (eg ? edata : 32'h0));
    chk({tag, "_be"},    32'(bus.MemByteEn), 32'(cg ? cbe : (eg ? ebe : 4'h0)));
    @(posedge Clock);
    #1;
  endtask

  task automatic idle(input string tag);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask
  task automatic core_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    drive(1, 1, a, d, be, 0, 0, 0, 0, 0, 0, 0, 0, 0, "core_wr");
  endtask
  task automatic core_rd(input logic [31:0] a, input logic [31:0] exp);
    drive(1, 0, a, 0, 0, 0, 0, 0, 0, 0, 0, 0, exp, 0, "core_rd");
  endtask
  task automatic ext_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    drive(0, 0, 0, 0, 0, 1, 1, a, d, be, 0, 1, 0, 0, "ext_wr");
  endtask
  task automatic ext_rd(input logic [31:0] a, input logic [31:0] exp);
    drive(0, 0, 0, 0, 0, 1, 0, a, 0, 0, 0, 1, 0, exp, "ext_rd");
  endtask

  // Pulse reset between scenarios; hold registers return to zero.
  task automatic pulse_reset();
    Rst = 1'b1;
    core_last = '0;
    ext_last  = '0;
    @(negedge Clock);
    chk("rst_state", 32'(dbg_state), 32'(CORE_PRI));
    chk("rst_starve", 32'(dbg_starve), 32'h0);
    @(posedge Clock);
    #1;
    Rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Rst = 1'b1;
    bus.CoreReq = 0; bus.CoreWr = 0; bus.CoreAddr = 0; bus.CoreWrData = 0; bus.CoreByteEn = 0;
    bus.ExtReq  = 0; bus.ExtWr  = 0; bus.ExtAddr  = 0; bus.ExtWrData  = 0; bus.ExtByteEn  = 0;
    repeat (2) @(posedge Clock);
    #1;
    Rst = 1'b0;

    // 1: reset lands on an in-flight ext read; the return must be dropped.
    bus.ExtReq = 1; bus.ExtWr = 0; bus.ExtAddr = 32'h1004;
    @(negedge Clock);
    chk("t1_egnt_pre", 32'(bus.ExtGnt), 32'h1);
    @(posedge Clock);
    #1;
    Rst = 1'b1;
    @(negedge Clock);
    chk("t1_ext_rdvalid_rst", 32'(bus.ExtRdValid), 32'h0);
    chk("t1_core_rdvalid_rst", 32'(bus.CoreRdValid), 32'h0);
    chk("t1_egnt_rst", 32'(bus.ExtGnt), 32'h0);
    chk("t1_rden_rst", 32'(bus.MemRdEn), 32'h0);
    chk("t1_addr_rst", bus.MemAddr, 32'h0);
    chk("t1_state_rst", 32'(dbg_state), 32'(CORE_PRI));
    chk("t1_ext_data_rst", bus.ExtRdData, 32'h0);
    @(posedge Clock);
    #1;
    bus.ExtReq = 0;
    Rst = 1'b0;
    @(negedge Clock);
    chk("t1_ext_rdvalid_post", 32'(bus.ExtRdValid), 32'h0);
    chk("t1_stall_post", 32'(bus.CoreStall), 32'h0);
    @(posedge Clock);
    #1;

    // 2: core-only write then read back.
    core_wr(32'h1004, 32'hDEADBEEF, 4'hF);
    core_rd(32'h1004, 32'hDEADBEEF);
    idle("t2_idle");

    // 3: both held; core wins 0-3, ext forced on 4, core again on 5.
    for (int i = 0; i < 6; i++)
      drive(1, 0, 32'h1004, 0, 0, 1, 0, 32'h1004, 0, 0,
            (i == 4), (i == 4), 32'hDEADBEEF, 32'hDEADBEEF, "t3");
    idle("t3_idle");

    // 4: alternating read owners, partial byte-enable writes.
    core_wr(32'h1000, 32'h11112222, 4'hF);
    core_wr(32'h1008, 32'h33334444, 4'hF);
    core_rd(32'h1000, 32'h11112222);
    ext_rd(32'h1008, 32'h33334444);
    ext_rd(32'h1000, 32'h11112222);
    core_rd(32'h1008, 32'h33334444);
    core_wr(32'h1004, 32'h0000CAFE, 4'h3);
    core_rd(32'h1004, 32'hDEADCAFE);
    ext_wr(32'h1008, 32'h99887766, 4'hC);
    ext_rd(32'h1008, 32'h99884444);
    core_rd(32'h1008, 32'h99884444);
    idle("t4_idle");

    // 5: external loader fills 16 words, core reads them back.
    for (int i = 0; i < 16; i++) ext_wr(32'h1000 + 32'(4 * i), 32'hA5000000 | 32'(i), 4'hF);
    for (int i = 0; i < 16; i++) core_rd(32'h1000 + 32'(4 * i), 32'hA5000000 | 32'(i));
    idle("t5_idle");
    idle("t5_idle");

    // 6: fresh reset, then 10 cycles of sustained conflict.
    pulse_reset();
`ifdef RVC_DMEM_ARB_STATS_EN
    chk("t6_cnt_core_rst", cnt_core, 32'd0);
    chk("t6_cnt_ext_rst", cnt_ext, 32'd0);
    chk("t6_cnt_conf_rst", cnt_conf, 32'd0);
`endif
    for (int i = 0; i < 10; i++)
      drive(1, 0, 32'h1004, 0, 0, 1, 0, 32'h1008, 0, 0,
            (i % 5 == 4), (i % 5 == 4), 32'hA5000001, 32'hA5000002, "t6");
    idle("t6_idle");
`ifdef RVC_DMEM_ARB_STATS_EN
    chk("t6_cnt_conflict", cnt_conf, 32'd10);
    chk("t6_cnt_ext", cnt_ext, 32'd2);
    chk("t6_cnt_core", cnt_core, 32'd8);
`endif
    chk("t6_state_end", 32'(dbg_state), 32'(CORE_PRI));

    // drain and confirm every expected return arrived
    idle("drain");
    idle("drain");
    chk("core_q_empty", 32'(core_exp_q.size()), 32'h0);
    chk("ext_q_empty", 32'(ext_exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
